// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, ID-resolved branch flushes, multi-cycle EX freeze.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned PERF_W = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs2_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mc_i,
    input  logic       id_br_taken_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_write_o,
    output logic       idex_bubble_o,
    output logic       exmem_bubble_o,
    output logic       ex_mc_done_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

    if (MC_LAT < 2 || MC_LAT > 15) begin : g_bad_mc_lat
        $error("hazard_sequencer: MC_LAT out of range 2..15");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("hazard_sequencer: PERF_W must be at least 1");
    end

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       freeze;
    logic       detect;
    logic       load_use;

    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        freeze         = 1'b0;
        detect         = 1'b0;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        ex_mc_done_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_mc_i) begin
                    freeze  = 1'b1;
                    cnt_d   = MC_INIT;
                    state_d = (MC_LAT == 2) ? RELEASE : BUSY;
                end else begin
                    detect = 1'b1;
                end
            end
            BUSY: begin
                freeze = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                ex_mc_done_o = 1'b1;
                detect       = 1'b1;
                cnt_d        = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Input-driven decisions are suppressed while reset is asserted.
        if (!rst_i) begin
            freeze       = 1'b0;
            detect       = 1'b0;
            ex_mc_done_o = 1'b0;
        end

        if (freeze) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_bubble_o = 1'b1;
        end else if (detect && load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (detect && id_br_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed, table-driven bench for hazard_sequencer (MC_LAT=4) plus hand-written multi-cycle sequences.
module tb_hazard_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_use_rs2_i, ex_memread_i, ex_mc_i, id_br_taken_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
    logic       idex_bubble_o, exmem_bubble_o, ex_mc_done_o;
`ifdef HAZ_PERF_CNT_EN
    logic [2:0] stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

`ifdef HAZ_PERF_CNT_EN
    hazard_sequencer #(.MC_LAT(4), .PERF_W(3)) dut (
`else
    hazard_sequencer #(.MC_LAT(4)) dut (
`endif
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .ex_mc_i(ex_mc_i),
        .id_br_taken_i(id_br_taken_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_write_o(idex_write_o), .idex_bubble_o(idex_bubble_o),
        .exmem_bubble_o(exmem_bubble_o), .ex_mc_done_o(ex_mc_done_o)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, ex_mc_done}
    logic [6:0] got;
    assign got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                  idex_bubble_o, exmem_bubble_o, ex_mc_done_o};

    localparam logic [6:0] NRM = 7'b1101000;
    localparam logic [6:0] LU  = 7'b0001100;
    localparam logic [6:0] FRZ = 7'b0000010;
    localparam logic [6:0] REL = 7'b1101001;
    localparam logic [6:0] FL  = 7'b1111000;
    localparam logic [6:0] RLU = 7'b0001101;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic       mr;
        logic [4:0] rd;
        logic       mc;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl[NVEC];

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use2, input logic mr, input logic [4:0] rd,
                                input logic mc, input logic br, input logic [6:0] exp);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2; v.mr = mr;
        v.rd = rd; v.mc = mc; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use2, input logic mc, input logic br);
        ex_memread_i = mr; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_use_rs2_i = use2; ex_mc_i = mc; id_br_taken_i = br;
    endtask

    initial begin
        int cyc;
        //            rst rs1 rs2 u2 mr rd mc br exp
        tbl[0]  = mk(0,  5,  0, 0, 1, 5, 1, 1, NRM); // reset gates everything
        tbl[1]  = mk(1,  0,  0, 0, 0, 0, 0, 0, NRM);
        tbl[2]  = mk(1,  5,  1, 1, 1, 5, 0, 0, LU);  // load x5; add x6,x5,x1
        tbl[3]  = mk(1,  5,  1, 1, 0, 5, 0, 0, NRM);
        tbl[4]  = mk(1,  0,  0, 0, 1, 0, 0, 0, NRM); // x0 never a hazard
        tbl[5]  = mk(1,  3,  7, 0, 1, 7, 0, 0, NRM); // rs2 match but unused
        tbl[6]  = mk(1,  3,  7, 1, 1, 7, 0, 0, LU);
        tbl[7]  = mk(1,  3,  4, 1, 0, 0, 0, 1, FL);
        tbl[8]  = mk(1,  5,  4, 1, 1, 5, 0, 1, LU);  // load-use beats branch
        tbl[9]  = mk(1,  5,  4, 1, 0, 5, 0, 1, FL);
        tbl[10] = mk(1,  5,  0, 0, 1, 5, 1, 1, FRZ); // freeze beats load-use/branch
        tbl[11] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[12] = mk(1,  0,  0, 0, 0, 0, 1, 1, FRZ);
        tbl[13] = mk(1,  0,  0, 0, 0, 0, 1, 0, REL);
        tbl[14] = mk(1,  0,  0, 0, 0, 0, 0, 0, NRM);
        tbl[15] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[16] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[17] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[18] = mk(1,  9,  0, 0, 1, 9, 1, 1, RLU); // load-use evaluated in RELEASE
        tbl[19] = mk(1,  9,  0, 0, 0, 9, 0, 1, FL);
        tbl[20] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[21] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[22] = mk(0,  0,  0, 0, 0, 0, 1, 0, NRM); // reset in BUSY, cnt=1
        tbl[23] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ); // fresh full count
        tbl[24] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[25] = mk(1,  0,  0, 0, 0, 0, 1, 0, FRZ);
        tbl[26] = mk(1,  0,  0, 0, 0, 0, 1, 0, REL);
        tbl[27] = mk(1,  0,  0, 0, 0, 0, 0, 0, NRM);

        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_i);
            rst_i = tbl[i].rst;
            drive(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].use2, tbl[i].mc, tbl[i].br);
            #2;
            chk($sformatf("vec%0d", i), 32'(got), 32'(tbl[i].exp));
        end

        // Asynchronous reset mid-BUSY, without waiting for a clock edge
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk_i);
        #3;
        chk("busy_before_async_rst", 32'(got), 32'(FRZ));
        rst_i = 1'b0;
        #1;
        chk("async_rst_immediate", 32'(got), 32'(NRM));
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;

        // Bounded wait for ex_mc_done: three freeze cycles precede it
        @(negedge clk_i);
        ex_mc_i = 1'b1;
        cyc = 0;
        #2;
        while (!ex_mc_done_o && cyc < 20) begin
            @(negedge clk_i);
            #2;
            cyc++;
        end
        chk("mc_done_latency", 32'(cyc), 32'd3);
        @(negedge clk_i);
        ex_mc_i = 1'b0;
        #2;
        chk("mc_back_idle", 32'(got), 32'(NRM));

`ifdef HAZ_PERF_CNT_EN
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        chk("perf_reset", 32'(stall_cnt_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        ex_mc_i = 1'b1;
        repeat (4) @(negedge clk_i);
        drive(1, 5, 5, 0, 0, 0, 0);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("perf_mc_plus_lu", 32'(stall_cnt_o), 32'd4);
        drive(1, 5, 5, 0, 0, 0, 0);
        repeat (5) @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("perf_saturate", 32'(stall_cnt_o), 32'd7);
        @(negedge clk_i);
        #2;
        chk("perf_hold", 32'(stall_cnt_o), 32'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
